parallel_in: RTL and testbench
==============================

// Module: parallel_in
// PURPOSE
//  Memory-mapped parallel input port: the read-side counterpart of the parallel output port.
//  Samples external pins (switches/buttons) through a 2-flop synchronizer and a debouncer.
//  Exposes the debounced value plus a sticky "changed" status to the RV32I load path.
//  Sits on the data-memory bus beside the output port; decoded by low address byte.
// PARAMETERS
//  WIDTH           8      data/address/pin width
//  DATA_ADDR       8'hFE  address returning debounced pin value
//  STATUS_ADDR     8'hFD  address returning {0.., Changed}; reading it clears Changed
//  DEBOUNCE_CYCLES 4      cycles sync'd input must be stable before commit (>=2)
// PORTS
//  clk      in   1      system clock, all state on rising edge
//  rst      in   1      synchronous reset, active-high
//  RE       in   1      bus read enable (load in progress)
//  Address  in   WIDTH  bus address (low byte)
//  PinIn    in   WIDTH  asynchronous external pins
//  DataOut  out  WIDTH  read data to load mux (combinational from registered state)
//  Changed  out  1      sticky flag: debounced value changed since last status read
// BEHAVIOUR
//  Reset (rst=1 at edge): sync1, sync2, cand, stable, cnt, Changed <= 0. DataOut=0 while nothing decoded.
//  Sync: sync1 <= PinIn; sync2 <= sync1. No logic between stages.
//  Debounce (per edge, vector-wide, cnt width $clog2(DEBOUNCE_CYCLES)):
//   - sync2 != cand              : cand <= sync2, cnt <= 0
//   - cnt == DEBOUNCE_CYCLES-1   : if stable != cand -> stable <= cand; cnt holds (saturates)
//   - else                       : cnt <= cnt+1
//  Latency: PinIn stable before edge 1 -> stable updated at edge 3+DEBOUNCE_CYCLES (7 at default).
//  Glitch: any sync2 pulse shorter than DEBOUNCE_CYCLES cycles never reaches stable.
//  Changed: set on the edge stable takes a new value; cleared on edge where RE=1 & Address==STATUS_ADDR.
//   Simultaneous set and clear -> set wins (Changed stays 1).
//  Read mux (combinational):
//   - RE & Address==DATA_ADDR   -> DataOut = stable
//   - RE & Address==STATUS_ADDR -> DataOut = {WIDTH-1 zeros, Changed} (pre-clear value)
//   - otherwise                 -> DataOut = 0
//  Reads of DATA_ADDR have no side effects. Reset mid-debounce discards cand/cnt progress.
// CONFIGURATION
//  PARALLEL_IN_DEBOUNCE_EN
//   defined  : debouncer as above; latency 3+DEBOUNCE_CYCLES edges.
//   undefined: cand/cnt removed; stable <= sync2 every edge (latency 3 edges);
//              Changed set when sync2 != stable; DEBOUNCE_CYCLES ignored.
// TESTING
//  1 rst=1 two cycles, PinIn=8'hA5 -> stable=0, Changed=0, read 8'hFE returns 8'h00.
//  2 PinIn 0->8'h3C held (debounce on) -> read 8'hFE = 8'h00 through edge 6, 8'h3C from edge 7; Changed=1 at edge 7.
//  3 PinIn pulse 8'hFF for 2 cycles then 0 -> stable stays 8'h00, Changed stays 0.
//  4 After scenario 2, read 8'hFD -> DataOut=8'h01, Changed=0 next cycle; second read returns 8'h00.
//  5 Status read on same edge stable changes 8'h3C->8'h0F -> DataOut=8'h01, Changed remains 1.
//  6 RE=0 or Address=8'h10 -> DataOut=8'h00; macro undefined: PinIn=8'h81 -> stable=8'h81 at edge 3.

Source files
------------

// File: rtl/parallel_in_if.sv
// ============================================================================
// parallel_in_if : data-memory bus view of the parallel input port
//                  (read enable, low address byte, read data back to load mux)
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

interface parallel_in_if #(
  parameter int WIDTH = 8
);
  logic             RE;
  logic [WIDTH-1:0] Address;
  logic [WIDTH-1:0] DataOut;

  modport master (output RE, output Address, input  DataOut);
  modport slave  (input  RE, input  Address, output DataOut);
endinterface

`default_nettype wire

// File: rtl/parallel_in.sv
// ============================================================================
// parallel_in : memory-mapped parallel input port with 2-flop sync, debouncer
//               and sticky change flag.  Macro PARALLEL_IN_DEBOUNCE_EN enables
//               the debouncer; without it the synced pins commit every edge.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module parallel_in #(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] DATA_ADDR       = 8'hFE,
  parameter logic [WIDTH-1:0] STATUS_ADDR     = 8'hFD,
  parameter int               DEBOUNCE_CYCLES = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  parallel_in_if.slave          bus,
  input  wire logic [WIDTH-1:0] PinIn,
  output logic                  Changed
);

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
    $error("parallel_in: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic             r_changed;
  logic             w_set;
  logic             w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= PinIn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PARALLEL_IN_DEBOUNCE_EN
  localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_cand;
  logic [CW-1:0]    r_cnt;

  // A commit needs the candidate to still match sync2 on the saturating edge.
  assign w_set = (r_sync2 == r_cand) && (r_cnt == C_CNT_MAX) && (r_stable != r_cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt == C_CNT_MAX) begin
      if (w_set) begin
        r_stable <= r_cand;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_set = (r_sync2 != r_stable);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
    end else begin
      r_stable <= r_sync2;
    end
  end
`endif

  assign w_clr = bus.RE && (bus.Address == STATUS_ADDR);

  // Set has priority so a change landing on a status read is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else if (w_set) begin
      r_changed <= 1'b1;
    end else if (w_clr) begin
      r_changed <= 1'b0;
    end
  end

  assign Changed = r_changed;

  always_comb begin
    bus.DataOut = '0;
    if (bus.RE && (bus.Address == DATA_ADDR)) begin
      bus.DataOut = r_stable;
    end else if (w_clr) begin
      bus.DataOut = {{(WIDTH-1){1'b0}}, r_changed};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_parallel_in.sv
// ============================================================================
// tb_parallel_in : directed and randomized checks of parallel_in against a
//                  sliding-window model of the pin history.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parallel_in;

`ifdef PARALLEL_IN_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 0;
`endif
  localparam int LAT = 3 + D;
  localparam int HN  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] PinIn;
  logic       Changed;

  parallel_in_if #(.WIDTH(8)) bus ();

  parallel_in #(
    .WIDTH(8), .DATA_ADDR(8'hFE), .STATUS_ADDR(8'hFD), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .PinIn(PinIn), .Changed(Changed)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: history of values entering the synchronizer, one per edge.
  logic [7:0] hq[$];
  logic [7:0] m_stable;
  bit         m_changed;

  function automatic logic [7:0] model_read(input logic re, input logic [7:0] a);
    if (re && a == 8'hFE) return m_stable;
    if (re && a == 8'hFD) return {7'b0, m_changed};
    return 8'h00;
  endfunction

  function automatic void model_edge(input logic r, input logic [7:0] p,
                                     input logic re, input logic [7:0] a);
    logic [7:0] cand;
    bit same, set;
    if (r) begin
      foreach (hq[i]) hq[i] = 8'h00;
      m_stable  = 8'h00;
      m_changed = 1'b0;
    end else begin
      hq.push_back(p);
      void'(hq.pop_front());
      // Value two edges old commits once it has held for D+1 consecutive edges.
      cand = hq[HN-3];
      same = 1'b1;
      for (int i = HN - 3 - D; i < HN - 3; i++) if (hq[i] != cand) same = 1'b0;
      set = same && (cand != m_stable);
      if (set) m_stable = cand;
      if (set) m_changed = 1'b1;
      else if (re && a == 8'hFD) m_changed = 1'b0;
    end
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] p, input logic re, input logic [7:0] a);
    @(negedge clk);
    rst = r; PinIn = p; bus.RE = re; bus.Address = a;
    #1;
    chk8("dataout", bus.DataOut, model_read(re, a));
    @(posedge clk);
    model_edge(r, p, re, a);
    #1;
    chk8("changed", {7'b0, Changed}, {7'b0, m_changed});
  endtask

  initial begin
    logic [7:0] pv, av;
    int hold;
    for (int i = 0; i < HN; i++) hq.push_back(8'h00);
    m_stable = 8'h00; m_changed = 1'b0;
    rst = 1'b1; PinIn = 8'h00; bus.RE = 1'b0; bus.Address = 8'h00;

    // Reset with pins active, then data read returns zero.
    step(1'b1, 8'hA5, 1'b1, 8'hFE);
    step(1'b1, 8'hA5, 1'b1, 8'hFE);
    chk8("rst_changed", {7'b0, Changed}, 8'h00);
    @(negedge clk); PinIn = 8'h00; bus.RE = 1'b1; bus.Address = 8'hFE; #1;
    chk8("rst_data", bus.DataOut, 8'h00);

    // Two-cycle glitch after quiet pins.
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 8'hFE);
    step(1'b0, 8'hFF, 1'b1, 8'hFE);
    step(1'b0, 8'hFF, 1'b1, 8'hFE);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b1, 8'hFE);
`ifdef PARALLEL_IN_DEBOUNCE_EN
      chk8("glitch_changed", {7'b0, Changed}, 8'h00);
`endif
    end

    // Held value commits exactly LAT edges after it is first applied.
    step(1'b1, 8'h00, 1'b0, 8'h00);
    for (int k = 1; k <= LAT + 1; k++) begin
      step(1'b0, 8'h3C, 1'b1, 8'hFE);
      chk8("latency_changed", {7'b0, Changed}, (k >= LAT) ? 8'h01 : 8'h00);
    end
    @(negedge clk); bus.RE = 1'b1; bus.Address = 8'hFE; #1;
    chk8("latency_data", bus.DataOut, 8'h3C);

    // Status read returns 1 then clears; second read sees 0.
    step(1'b0, 8'h3C, 1'b1, 8'hFD);
    chk8("clr_changed", {7'b0, Changed}, 8'h00);
    @(negedge clk); bus.RE = 1'b1; bus.Address = 8'hFD; #1;
    chk8("second_status", bus.DataOut, 8'h00);

    // Status read on the very edge the stable value changes.
    for (int k = 1; k < LAT; k++) step(1'b0, 8'h0F, 1'b1, 8'hFE);
    step(1'b0, 8'h0F, 1'b1, 8'hFD);
    chk8("set_wins", {7'b0, Changed}, 8'h01);

    // Undecoded accesses return zero.
    step(1'b0, 8'h0F, 1'b0, 8'hFE);
    step(1'b0, 8'h0F, 1'b1, 8'h10);

    // Non-debounced build: 81 reaches stable on edge 3.
`ifndef PARALLEL_IN_DEBOUNCE_EN
    step(1'b1, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h81, 1'b0, 8'h00);
    @(negedge clk); bus.RE = 1'b1; bus.Address = 8'hFE; #1;
    chk8("nodeb_edge3", bus.DataOut, 8'h81);
`endif

    // Randomized pins with variable hold times, reads and rare resets.
    pv = 8'h00;
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        pv = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) pv = pv & 8'h03;
        hold = $urandom_range(1, 9);
      end
      hold--;
      case ($urandom_range(0, 3))
        0: av = 8'hFE;
        1: av = 8'hFD;
        2: av = 8'h10;
        default: av = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 99) == 0), pv, 1'($urandom_range(0, 1)), av);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
